fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10, program counter / instruction ROM address width.
REQ-002 Parameter INST_W, default 9, instruction word width.
REQ-003 Parameter CNT_W, default 16, run-cycle counter width.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse; begins or restarts program at address 0.
REQ-007 inst_in  input  INST_W  ROM data, combinational function of pc.
REQ-008 stall  input  1  downstream cannot accept; hold pc and instruction register.
REQ-009 redirect  input  1  taken branch/jump from decode; load redirect_pc.
REQ-010 redirect_pc  input  PC_W  absolute target address.
REQ-011 halt_req  input  1  decode has a halt instruction in the instruction register.
REQ-012 pc  output  PC_W  current fetch address to ROM.
REQ-013 inst_out  output  INST_W  instruction register to decode.
REQ-014 inst_valid  output  1  inst_out holds a live instruction.
REQ-015 halt  output  1  registered; program finished or fetch overran ROM.
REQ-016 cycle_count  output  CNT_W  RUN-state cycles since last start.

Function
REQ-017 FSM states IDLE, RUN, HALTED; only RUN fetches.
REQ-018 IDLE: start -> RUN, pc=0, inst_valid=0, cycle_count=0; other inputs ignored.
REQ-019 RUN, per-edge priority: start > halt_req > redirect > stall > sequential fetch.
REQ-020 Sequential fetch: inst_out<=inst_in, inst_valid<=1, pc<=pc+1.
REQ-021 stall (no higher event): pc, inst_out, inst_valid unchanged.
REQ-022 redirect: pc<=redirect_pc, inst_valid<=0 (one-cycle bubble); redirect overrides concurrent stall.
REQ-023 halt_req with inst_valid=1: -> HALTED, halt<=1, inst_valid<=0, pc frozen; halt_req with inst_valid=0 ignored.
REQ-024 Overrun: sequential fetch with pc = 2^PC_W-1 -> HALTED, halt<=1, pc not wrapped, inst_valid<=0.
REQ-025 HALTED: all state frozen, halt held 1 until start; start -> RUN exactly as REQ-018, halt<=0 same edge.
REQ-026 start during RUN: restart per REQ-018 regardless of stall/redirect/halt_req.
REQ-027 cycle_count increments every RUN cycle including stall/bubble cycles; saturates at 2^CNT_W-1, no wrap.
REQ-028 Latency: instruction at address A appears on inst_out one edge after pc=A with no stall.

Reset
REQ-029 Reset asynchronously forces IDLE, pc=0, inst_out=0, inst_valid=0, halt=0, cycle_count=0.
REQ-030 Reset mid-RUN or in HALTED discards all state; no fetch until next start after Reset deasserts.
REQ-031 start sampled while Reset high is ignored.

Structure
REQ-032 Shared package holds FSM state enum (IDLE/RUN/HALTED) and default PC_W/INST_W/CNT_W constants.
REQ-033 Single module; saturating counter as sub-module sat_counter (parameter width, inputs clear/enable).
REQ-034 ROM stays outside the block; only pc/inst_in cross the boundary.

Verification
REQ-035 Reset, start, ROM[0..3]=9'h001..9'h004, no stall -> inst_out 001,002,003,004 on consecutive edges, pc 1..4.
REQ-036 stall high 3 cycles with pc=5 -> pc stays 5, inst_out/inst_valid unchanged, cycle_count still +3.
REQ-037 redirect with redirect_pc=10'h020 while stall=1 -> next edge pc=0x020, inst_valid=0; following edge inst_out=ROM[0x20].
REQ-038 halt_req with inst_valid=1 at cycle_count=7 -> halt=1 next edge, pc frozen, cycle_count stays 8; start -> halt=0, pc=0.
REQ-039 Free-run from redirect_pc=10'h3FE -> fetch 0x3FE, 0x3FF, then halt=1, pc=0x3FF.
REQ-040 Reset pulse mid-RUN at pc=0x12 -> immediately pc=0, halt=0, inst_valid=0; remains IDLE until start.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and default widths.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int DEF_PC_W   = 10;
    localparam int DEF_INST_W = 9;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the ROM address, registers the fetched word for
// decode, and handles stall, redirect, halt and ROM-overrun.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic [INST_W-1:0] inst_in,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              halt,
    output logic [CNT_W-1:0]  cycle_count
);

    fetch_state_t      state, state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [INST_W-1:0] inst_nxt;
    logic              valid_nxt;
    logic              halt_nxt;
    logic              pc_at_top;
    logic              halt_take;
    logic              running;

    assign pc_at_top = (pc == '1);
    // A halt request only counts when decode really holds an instruction.
    assign halt_take = halt_req & inst_valid;
    assign running   = (state == RUN);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (start)                              state_nxt = RUN;
                else if (halt_take)                     state_nxt = HALTED;
                else if (!redirect && !stall && pc_at_top) state_nxt = HALTED;
            end
            HALTED: begin
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt    = pc;
        inst_nxt  = inst_out;
        valid_nxt = inst_valid;
        halt_nxt  = halt;
        if (start) begin
            pc_nxt    = '0;
            valid_nxt = 1'b0;
            halt_nxt  = 1'b0;
        end else if (running) begin
            if (halt_take) begin
                halt_nxt  = 1'b1;
                valid_nxt = 1'b0;
            end else if (redirect) begin
                pc_nxt    = redirect_pc;
                valid_nxt = 1'b0;
            end else if (stall) begin
                pc_nxt    = pc;
            end else if (pc_at_top) begin
                // Fetching past the last ROM word: stop rather than wrap to 0.
                halt_nxt  = 1'b1;
                valid_nxt = 1'b0;
            end else begin
                inst_nxt  = inst_in;
                valid_nxt = 1'b1;
                pc_nxt    = pc + PC_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc         <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            halt       <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            inst_out   <= inst_nxt;
            inst_valid <= valid_nxt;
            halt       <= halt_nxt;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cycle_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .clear (start),
        .enable(running),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus random traffic against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INST_W  = 9;
    localparam int CNT_W   = 6;
    localparam int PC_MAX  = (1 << PC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic              start = 1'b0;
    logic [INST_W-1:0] inst_in;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              halt_req = 1'b0;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst_out;
    logic              inst_valid;
    logic              halt;
    logic [CNT_W-1:0]  cycle_count;

    logic [INST_W-1:0] rom [0:PC_MAX];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int pc;
        bit valid;
        int inst;
        bit halt;
        int cnt;
    } exp_t;
    exp_t sbq[$];

    // model state
    bit m_run = 0;
    bit m_halt = 0;
    bit m_valid = 0;
    int m_pc = 0;
    int m_inst = 0;
    int m_cnt = 0;

    always #5 CLK = ~CLK;
    assign inst_in = rom[pc];

    fetch_unit #(
        .PC_W  (PC_W),
        .INST_W(INST_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .inst_in    (inst_in),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .pc         (pc),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .halt       (halt),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_valid = 0; m_pc = 0; m_inst = 0; m_cnt = 0;
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, queue the expectation.
    task automatic step(input bit s, input bit st, input bit rd, input int rpc, input bit hr);
        int w;
        exp_t e;
        w = int'(rom[m_pc]);
        start = s; stall = st; redirect = rd; redirect_pc = PC_W'(rpc); halt_req = hr;
        @(posedge CLK);
        #1;
        if (Reset) begin
            model_reset();
        end else if (s) begin
            m_run = 1; m_halt = 0; m_pc = 0; m_valid = 0; m_cnt = 0;
        end else if (m_run) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (hr && m_valid) begin
                m_run = 0; m_halt = 1; m_valid = 0;
            end else if (rd) begin
                m_pc = rpc; m_valid = 0;
            end else if (st) begin
                m_pc = m_pc;
            end else if (m_pc == PC_MAX) begin
                m_run = 0; m_halt = 1; m_valid = 0;
            end else begin
                m_inst = w; m_valid = 1; m_pc = m_pc + 1;
            end
        end
        e.pc = m_pc; e.valid = m_valid; e.inst = m_inst; e.halt = m_halt; e.cnt = m_cnt;
        sbq.push_back(e);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset assertion between clock edges, checked before the next edge.
    task automatic pulse_reset();
        @(negedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_pc", 32'(pc), 0);
        chk("async_rst_halt", 32'(halt), 0);
        chk("async_rst_valid", 32'(inst_valid), 0);
        chk("async_rst_inst", 32'(inst_out), 0);
        chk("async_rst_cnt", 32'(cycle_count), 0);
        model_reset();
    endtask

    // Monitor: compare every cycle the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_pc", 32'(pc), e.pc);
                chk("sb_valid", 32'(inst_valid), 32'(e.valid));
                chk("sb_halt", 32'(halt), 32'(e.halt));
                chk("sb_cnt", 32'(cycle_count), e.cnt);
                if (e.valid) chk("sb_inst", 32'(inst_out), e.inst);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit s;
        int rpc;
        for (int i = 0; i <= PC_MAX; i++) rom[i] = INST_W'($urandom);
        for (int i = 0; i < 4; i++) rom[i] = INST_W'(i + 1);

        #3;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_inst", 32'(inst_out), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_cnt", 32'(cycle_count), 0);
        #9;
        Reset = 1'b0;

        // Straight-line fetch of ROM[0..3]
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle_step();
        chk("seq_pc4", 32'(pc), 4);
        chk("seq_inst4", 32'(inst_out), 4);
        idle_step();
        // Stall for three cycles at pc=5
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("stall_pc", 32'(pc), 5);
        chk("stall_cnt", 32'(cycle_count), 8);
        chk("stall_inst", 32'(inst_out), 32'(rom[4]));

        // Redirect beats a concurrent stall
        step(0, 1, 1, 'h020, 0);
        chk("redir_pc", 32'(pc), 'h020);
        chk("redir_valid", 32'(inst_valid), 0);
        idle_step();
        chk("redir_inst", 32'(inst_out), 32'(rom['h20]));

        // Halt request at cycle_count=7
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) idle_step();
        step(0, 0, 0, 0, 1);
        idle_step();
        idle_step();
        chk("halt_flag", 32'(halt), 1);
        chk("halt_pc", 32'(pc), 7);
        chk("halt_cnt", 32'(cycle_count), 8);
        step(1, 0, 0, 0, 0);
        chk("restart_halt", 32'(halt), 0);
        chk("restart_pc", 32'(pc), 0);

        // Overrun off the top of the ROM
        idle_step();
        step(0, 0, 1, 'h3FE, 0);
        idle_step();
        chk("top_inst", 32'(inst_out), 32'(rom['h3FE]));
        idle_step();
        chk("overrun_halt", 32'(halt), 1);
        chk("overrun_pc", 32'(pc), 'h3FF);
        idle_step();

        // Reset mid-run, start ignored while Reset is high
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 'h12; i++) idle_step();
        chk("pre_rst_pc", 32'(pc), 'h12);
        pulse_reset();
        step(1, 0, 0, 0, 0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) idle_step();
        chk("post_rst_idle_pc", 32'(pc), 0);
        chk("post_rst_idle_cnt", 32'(cycle_count), 0);

        // Counter saturation
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 70; i++) step(0, 1, 0, 0, 0);
        chk("sat_cnt", 32'(cycle_count), CNT_MAX);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                step($urandom_range(0, 1) == 1, 0, 0, 0, 0);
                Reset = 1'b0;
            end else begin
                s = m_run ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
                rpc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PC_MAX))
                                                  : int'($urandom_range(PC_MAX - 7, PC_MAX));
                step(s, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rpc,
                     $urandom_range(0, 9) == 0);
            end
        end

        start = 1'b0; stall = 1'b0; redirect = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
